// File: rtl/pe_pkg.sv
`default_nettype none
// pe_pkg: default widths shared with the PE array top, plus rounding and parameter-legality helpers.
// Rev 1.0 -- used by pe_mac and pe_requant.
package pe_pkg;

  localparam int PE_DATA_W   = 8;
  localparam int PE_WEIGHT_W = 8;
  localparam int PE_ACC_W    = 24;
  localparam int PE_OUT_W    = 8;
  localparam int PE_SHIFT    = 0;

  function automatic bit pe_params_ok(input int data_w, input int weight_w,
                                      input int acc_w, input int out_w, input int shift);
    return (acc_w >= data_w + weight_w) && (acc_w <= 62) && (out_w >= 2) &&
           (out_w <= acc_w) && (shift >= 0) && (shift < acc_w);
  endfunction

  // Half-LSB bias that turns the arithmetic shift into round-half-up.
  function automatic longint unsigned pe_round_const(input int shift);
    return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_requant.sv
`default_nettype none
// pe_requant: combinational round / arithmetic-shift / saturate of an ACC_W sum down to OUT_W.
// Rev 1.0 -- PE_RELU_EN clamps negative results to zero after saturation.
module pe_requant
  import pe_pkg::*;
#(
  parameter int ACC_W = PE_ACC_W,
  parameter int OUT_W = PE_OUT_W,
  parameter int SHIFT = PE_SHIFT
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] ofm
);

  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(pe_round_const(SHIFT));
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] sat;

  // One guard bit keeps the rounding bias from wrapping the largest positive sum.
  always_comb begin
    biased  = $signed({acc[ACC_W-1], acc}) + RND;
    shifted = biased >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = shifted;
    end
    ofm = sat[OUT_W-1:0];
`ifdef PE_RELU_EN
    if (sat[ACC_W]) begin
      ofm = '0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// pe_mac: 3-stage signed MAC PE (multiply, windowed accumulate, requantise) with sticky overflow flag.
// Rev 1.0 -- optional ReLU on the result via PE_RELU_EN.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int WEIGHT_W = PE_WEIGHT_W,
  parameter int ACC_W    = PE_ACC_W,
  parameter int OUT_W    = PE_OUT_W,
  parameter int SHIFT    = PE_SHIFT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   ifm,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                pe_restart,
  input  logic                pe_finish,
  output logic [OUT_W-1:0]    ofm,
  output logic                ofm_valid,
  output logic                ofm_ovf
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  generate
    if (!pe_params_ok(DATA_W, WEIGHT_W, ACC_W, OUT_W, SHIFT)) begin : g_param_check
      $error("pe_mac: illegal DATA_W/WEIGHT_W/ACC_W/OUT_W/SHIFT combination");
    end
  endgenerate

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_restart_q, s1_restart_d;
  logic                     s1_finish_q, s1_finish_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;
  logic [OUT_W-1:0]         ofm_q, ofm_d;
  logic                     ofm_valid_q, ofm_valid_d;
  logic                     ofm_ovf_q, ofm_ovf_d;

  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     add_ovf;
  logic [OUT_W-1:0]         requant_ofm;

  pe_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc_q),
    .ofm (requant_ofm)
  );

  always_comb begin
    prod_d       = prod_q;
    s1_restart_d = s1_restart_q;
    s1_finish_d  = s1_finish_q;
    s1_valid_d   = in_valid;
    if (in_valid) begin
      prod_d       = PROD_W'($signed(ifm)) * PROD_W'($signed(weight));
      s1_restart_d = pe_restart;
      s1_finish_d  = pe_finish;
    end

    // Overflow: both addends share a sign that the wrapped sum does not.
    acc_base = s1_restart_q ? '0 : acc_q;
    prod_ext = ACC_W'(prod_q);
    acc_sum  = acc_base + prod_ext;
    add_ovf  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);

    acc_d  = acc_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (s1_valid_q) begin
      acc_d  = acc_sum;
      ovf_d  = (s1_restart_q ? 1'b0 : ovf_q) | add_ovf;
      done_d = s1_finish_q;
    end

    ofm_d       = ofm_q;
    ofm_ovf_d   = ofm_ovf_q;
    ofm_valid_d = done_q;
    if (done_q) begin
      ofm_d     = requant_ofm;
      ofm_ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_restart_q <= 1'b0;
      s1_finish_q  <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      ofm_q        <= '0;
      ofm_valid_q  <= 1'b0;
      ofm_ovf_q    <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      s1_valid_q   <= s1_valid_d;
      s1_restart_q <= s1_restart_d;
      s1_finish_q  <= s1_finish_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      ofm_q        <= ofm_d;
      ofm_valid_q  <= ofm_valid_d;
      ofm_ovf_q    <= ofm_ovf_d;
    end
  end

  assign ofm       = ofm_q;
  assign ofm_valid = ofm_valid_q;
  assign ofm_ovf   = ofm_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac.sv
`default_nettype none
// tb_pe_mac: shared stimulus into three pe_mac configurations (default, SHIFT=2, ACC_W=16),
// checked against a behavioural model through an expected-result queue.
module tb_pe_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       in_valid;
  logic       pe_restart;
  logic       pe_finish;
  logic [7:0] ifm;
  logic [7:0] weight;
  logic [7:0] ofm0, ofm1, ofm2;
  logic       v0, v1, v2;
  logic       o0, o1, o2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  pe_mac u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .ifm(ifm), .weight(weight),
    .pe_restart(pe_restart), .pe_finish(pe_finish), .ofm(ofm0), .ofm_valid(v0), .ofm_ovf(o0)
  );

  pe_mac #(.SHIFT(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .ifm(ifm), .weight(weight),
    .pe_restart(pe_restart), .pe_finish(pe_finish), .ofm(ofm1), .ofm_valid(v1), .ofm_ovf(o1)
  );

  pe_mac #(.ACC_W(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .ifm(ifm), .weight(weight),
    .pe_restart(pe_restart), .pe_finish(pe_finish), .ofm(ofm2), .ofm_valid(v2), .ofm_ovf(o2)
  );

  typedef struct packed {
    int   cyc;
    int   e0;
    int   e1;
    int   e2;
    logic f0;
    logic f1;
    logic f2;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint macc[3];
  bit     movf[3];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int acc_w_of(input int i);
    return (i == 2) ? 16 : 24;
  endfunction

  function automatic int shift_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int requant_m(input longint s, input int sh);
    longint v;
    v = s;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`ifdef PE_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      macc[i] = 0;
      movf[i] = 1'b0;
    end
    sb_q.delete();
  endtask

  task automatic beat(input int a, input int b, input bit r, input bit f);
    exp_t   e;
    longint p, base, s, hi, lo, span;
    int     res[3];
    @(posedge clk); #1;
    in_valid   = 1'b1;
    ifm        = 8'(a);
    weight     = 8'(b);
    pe_restart = r;
    pe_finish  = f;
    p = longint'(a) * longint'(b);
    for (int i = 0; i < 3; i++) begin
      span = longint'(1) << acc_w_of(i);
      hi   = (span >> 1) - 1;
      lo   = -(span >> 1);
      base = r ? 0 : macc[i];
      s    = base + p;
      movf[i] = (r ? 1'b0 : movf[i]) | ((s > hi) || (s < lo));
      s = s & (span - 1);
      if (s > hi) s = s - span;
      macc[i] = s;
      res[i]  = requant_m(s, shift_of(i));
    end
    if (f) begin
      e.cyc = cyc + 3;
      e.e0  = res[0];
      e.e1  = res[1];
      e.e2  = res[2];
      e.f0  = movf[0];
      e.f1  = movf[1];
      e.f2  = movf[2];
      sb_q.push_back(e);
    end
  endtask

  // Bubbles carry garbage on every other input; the DUT must ignore it.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid   = 1'b0;
      ifm        = 8'($urandom_range(0, 255));
      weight     = 8'($urandom_range(0, 255));
      pe_restart = 1'($urandom_range(0, 1));
      pe_finish  = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (v0 || v1 || v2)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ofm_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("latency", cyc, mon_e.cyc);
        check_eq("valid_all", {v0, v1, v2}, 3'b111);
        check_eq("ofm_default", $signed(ofm0), mon_e.e0);
        check_eq("ofm_shift2", $signed(ofm1), mon_e.e1);
        check_eq("ofm_acc16", $signed(ofm2), mon_e.e2);
        check_eq("ovf_default", o0, mon_e.f0);
        check_eq("ovf_shift2", o1, mon_e.f1);
        check_eq("ovf_acc16", o2, mon_e.f2);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    pe_restart = 1'b0;
    pe_finish  = 1'b0;
    ifm        = '0;
    weight     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ofm", {ofm0, ofm1, ofm2}, 0);
    check_eq("reset_valid", {v0, v1, v2}, 0);
    check_eq("reset_ovf", {o0, o1, o2}, 0);
    reset_n = 1'b1;

    // Finish without restart straight after reset accumulates from zero.
    beat(3, 4, 0, 1);
    idle(2);

    beat(2, 3, 1, 0);
    beat(-4, 5, 0, 0);
    beat(7, 1, 0, 1);
    idle(3);

    repeat (4) beat(127, 127, 0, 0);
    idle(1);
    beat(127, 127, 1, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 1);
    idle(3);

    beat(3, 3, 1, 1);
    beat(-3, 3, 1, 1);
    idle(2);

    beat(127, 127, 1, 0);
    beat(127, 127, 0, 1);
    beat(127, 127, 1, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 1);
    beat(1, 1, 1, 1);
    idle(2);

    beat(1, 1, 1, 1);
    idle(1);
    beat(2, 2, 1, 1);
    idle(2);
    beat(3, 3, 1, 1);
    beat(1, 2, 1, 1);
    beat(3, 4, 1, 1);
    beat(-5, 6, 1, 1);
    idle(3);

    for (int w = 0; w < 16; w++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             k == 0, k == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(1);

    // Leave a non-zero, overflowed result on the outputs, then reset mid-window.
    beat(127, 127, 1, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 0);
    beat(127, 127, 0, 1);
    idle(5);
    beat(9, 9, 1, 0);
    beat(4, 4, 0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset_ofm", {ofm0, ofm1, ofm2}, 0);
    check_eq("async_reset_valid", {v0, v1, v2}, 0);
    check_eq("async_reset_ovf", {o0, o1, o2}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    beat(5, 1, 1, 1);
    beat(6, 2, 0, 1);
    idle(6);

    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
